// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate-extension stage with a 2-entry skid buffer.
// Optional load-extension modes 5..7 are enabled by defining EXT_LOAD_EN.
module ext_pipe #(
  parameter int IMM_W    = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [2:0]       eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic             out_err
);

  localparam int F = OUT_W - IMM_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q;
  logic [OUT_W-1:0] head_ext_q;
  logic             head_err_q;
  logic [OUT_W-1:0] skid_ext_q;
  logic             skid_err_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [OUT_W-1:0] ext_d;
  logic             err_d;
  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] sx;
  logic             accept;
  logic             pop;

`ifdef EXT_LOAD_EN
  localparam int HW = (IMM_W > 16) ? 16 : IMM_W;
  logic [OUT_W-1:0] bs;
  logic [OUT_W-1:0] bz;
  logic [OUT_W-1:0] hs;
`endif

  // Extend the incoming immediate so entries are stored ready to use.
  always_comb begin
    zx = '0;
    zx[IMM_W-1:0] = imm;
    sx = {OUT_W{imm[IMM_W-1]}};
    sx[IMM_W-1:0] = imm;
`ifdef EXT_LOAD_EN
    bs = {OUT_W{imm[7]}};
    bs[7:0] = imm[7:0];
    bz = '0;
    bz[7:0] = imm[7:0];
    hs = {OUT_W{imm[HW-1]}};
    hs[HW-1:0] = imm[HW-1:0];
`endif
    ext_d = '0;
    err_d = 1'b0;
    case (eop)
      3'd0: ext_d = sx;
      3'd1: ext_d = zx;
      3'd2: ext_d = zx << F;
      3'd3: ext_d = sx << BR_SHIFT;
      3'd4: ext_d = zx << BR_SHIFT;
`ifdef EXT_LOAD_EN
      3'd5: ext_d = bs;
      3'd6: ext_d = bz;
      3'd7: ext_d = hs;
`endif
      default: begin
        ext_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Occupancy FSM; head drives the outputs, skid absorbs one stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      head_ext_q  <= '0;
      head_err_q  <= 1'b0;
      skid_ext_q  <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_ext_q  <= ext_d;
            head_err_q  <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_ext_q <= ext_d;
            head_err_q <= err_d;
          end else if (accept) begin
            skid_ext_q <= ext_d;
            skid_err_q <= err_d;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_ext_q <= skid_ext_q;
            head_err_q <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ext   = head_ext_q;
  assign out_err   = head_err_q;

endmodule
